instruction_cache: RTL and testbench
====================================

Name: instruction_cache

Overview:
- Parametrised, direct-mapped, read-only instruction cache.
- Replaces the fixed combinational instruction store between the fetch stage and a backing instruction memory.
- Hits return in one cycle.
- Misses refill one full line over a simple request/beat memory interface.
- Adds alignment fault reporting and whole-cache flush.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, instruction/word width
LINE_WORDS, 4, words per line (power of two, >=2)
NUM_LINES, 16, number of lines (power of two, >=2)
NOP_WORD, 32'h00000013, instruction returned on fault/reset (addi x0,x0,0)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
fetch_valid  input  1  fetch request present
fetch_address  input  ADDR_WIDTH  byte address of instruction
fetch_ready  output  1  cache can accept a request this cycle
resp_valid  output  1  one-cycle pulse, response present
resp_instruction  output  DATA_WIDTH  fetched instruction
resp_fault  output  1  address misaligned, valid with resp_valid
flush  input  1  invalidate all lines
mem_req_valid  output  1  line refill request
mem_req_address  output  ADDR_WIDTH  line-aligned byte address
mem_req_ready  input  1  memory accepts request
mem_resp_valid  input  1  one refill beat (word) present
mem_resp_data  input  DATA_WIDTH  refill word, ascending word order

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high, sampled on the rising edge of clock.
- Address split:
  - [1:0] byte offset.
  - Next log2(LINE_WORDS) bits: word select.
  - Next log2(NUM_LINES) bits: index.
  - Remainder: tag.
- Reset values:
  - fetch_ready=0 during reset.
  - resp_valid=0, resp_fault=0, resp_instruction=NOP_WORD.
  - mem_req_valid=0, mem_req_address=0.
  - All valid bits cleared; FSM enters IDLE.
  - Tag/data arrays are not reset.
- States: IDLE, REQ, FILL, RESP.
- IDLE:
  - fetch_ready=1.
  - A request is accepted when fetch_valid && fetch_ready.
  - Misaligned (offset!=0): next cycle resp_valid=1, resp_fault=1, resp_instruction=NOP_WORD. No memory traffic; stay in IDLE.
  - Hit (valid[index] && tag match): next cycle resp_valid=1, resp_fault=0, resp_instruction=data word. Stay in IDLE. Back-to-back hits give one response per cycle.
  - Miss: latch address; go to REQ.
- REQ:
  - mem_req_valid=1, mem_req_address = fetch address with word-select and offset bits zeroed.
  - Request and address are held stable until mem_req_ready=1, then go to FILL.
  - fetch_ready=0.
- FILL:
  - Each mem_resp_valid writes mem_resp_data to word (beat counter) of the line.
  - Counter wraps at LINE_WORDS.
  - After the last beat: write tag, set valid; go to RESP.
  - Beats may have gaps; fetch_ready=0.
- RESP:
  - resp_valid=1 with the requested word, read from the line just filled.
  - Go to IDLE.
  - Responses always return in request order; at most one miss outstanding.
- Flush:
  - In IDLE: all valid bits cleared at the clock edge. A fetch in the same cycle is looked up against the pre-flush state.
  - In REQ/FILL/RESP: flush is latched as pending. The refill completes and the response is delivered. Pending flush is applied on entry to IDLE, and fetch_ready stays 0 for that one cycle.
- Reset mid-refill:
  - FSM returns to IDLE and mem_req_valid drops.
  - Any beats arriving while in IDLE are ignored.
  - The partial line is never marked valid.
- resp_valid is 0 in every cycle without a response. resp_instruction holds its last value.
- mem_resp_valid outside FILL is ignored.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0], both reset to 0.
  - Increment once per accepted aligned hit or miss.
  - Both counters saturate at 32'hFFFFFFFF.
  - Faults count as neither.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, then fetch 0x0 (memory line 0 = 0x00500113, 0x00700093, 0x001101B3, 0x003181B3):
  - One mem_req at 0x0, 4 beats.
  - resp_instruction=0x00500113, resp_fault=0.
  - Then fetches 0x4, 0x8, 0xC hit back-to-back in 3 cycles with no mem_req.
- Fetch 0x2 → next cycle resp_valid=1, resp_fault=1, resp_instruction=0x00000013; mem_req_valid stays 0.
- Conflict misses:
  - Fill 0x0; fetch 0x100 (same index, different tag) → refill at 0x100.
  - Fetch 0x0 again → miss and refill at 0x0.
- Flush in IDLE after filling 0x0 → next fetch 0x4 misses, mem_req at 0x0.
- Flush asserted during FILL beat 2:
  - Response still delivered.
  - fetch_ready=0 for one cycle after return to IDLE.
  - Subsequent fetch 0x0 misses.
- Timing and reset stress:
  - Delay mem_req_ready 5 cycles; insert gaps between beats → address held stable, correct data returned.
  - Assert reset mid-FILL, then drive a stray beat → ignored. Fetch 0x0 misses.
  - With ICACHE_STATS_EN: 1 miss + 3 hits gives hit_count=3, miss_count=1.

Source files
------------

// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped, read-only instruction cache.
// One-cycle hit responses, single-line refill over a request/beat interface,
// misalignment fault reporting and whole-cache flush.
// Optional build macro ICACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module instruction_cache #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned LINE_WORDS = 4,
   parameter int unsigned NUM_LINES  = 16,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD = 32'h00000013
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  fetch_valid,
   input  logic [ADDR_WIDTH-1:0] fetch_address,
   output logic                  fetch_ready,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_instruction,
   output logic                  resp_fault,
   input  logic                  flush,
   output logic                  mem_req_valid,
   output logic [ADDR_WIDTH-1:0] mem_req_address,
   input  logic                  mem_req_ready,
   input  logic                  mem_resp_valid,
   input  logic [DATA_WIDTH-1:0] mem_resp_data
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]           hit_count,
   output logic [31:0]           miss_count
`endif
);

   localparam int unsigned WSEL_W = $clog2(LINE_WORDS);
   localparam int unsigned IDX_W  = $clog2(NUM_LINES);
   localparam int unsigned LOFF_W = 2 + WSEL_W;
   localparam int unsigned TAG_W  = ADDR_WIDTH - LOFF_W - IDX_W;

   typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} state_t;

   state_t state_q, state_d;

   // Line storage: valid bits are reset, tag/data arrays are not.
   logic [NUM_LINES-1:0]  valid_q;
   logic [TAG_W-1:0]      tag_q  [NUM_LINES];
   logic [DATA_WIDTH-1:0] data_q [NUM_LINES][LINE_WORDS];

   // Outstanding miss context.
   logic [TAG_W-1:0]      m_tag_q;
   logic [IDX_W-1:0]      m_idx_q;
   logic [WSEL_W-1:0]     m_wsel_q;
   logic [WSEL_W-1:0]     beat_q;
   logic [ADDR_WIDTH-1:0] req_addr_q;
   logic                  flush_pend_q;
   logic                  block_q;

   logic                  resp_valid_q;
   logic                  resp_fault_q;
   logic [DATA_WIDTH-1:0] resp_instr_q;

   logic [1:0]            f_off;
   logic [WSEL_W-1:0]     f_wsel;
   logic [IDX_W-1:0]      f_idx;
   logic [TAG_W-1:0]      f_tag;
   logic                  accept;
   logic                  misaligned;
   logic                  hit;
   logic                  last_beat;

   assign f_off  = fetch_address[1:0];
   assign f_wsel = fetch_address[2 +: WSEL_W];
   assign f_idx  = fetch_address[LOFF_W +: IDX_W];
   assign f_tag  = fetch_address[ADDR_WIDTH-1 -: TAG_W];

   assign accept     = fetch_valid && fetch_ready;
   assign misaligned = (f_off != 2'b00);
   assign hit        = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign last_beat  = (state_q == FILL) && mem_resp_valid
                       && (beat_q == WSEL_W'(LINE_WORDS - 1));

   assign resp_valid       = resp_valid_q;
   assign resp_fault       = resp_fault_q;
   assign resp_instruction = resp_instr_q;
   assign mem_req_address  = req_addr_q;

   // FSM state register.
   always_ff @(posedge clock) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_d       = state_q;
      fetch_ready   = 1'b0;
      mem_req_valid = 1'b0;
      case (state_q)
         IDLE: begin
            fetch_ready = !block_q && !reset;
            if (accept && !misaligned && !hit) state_d = REQ;
         end
         REQ: begin
            mem_req_valid = !reset;
            if (mem_req_ready) state_d = FILL;
         end
         FILL: begin
            if (last_beat) state_d = RESP;
         end
         RESP: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Lookup, miss capture, refill bookkeeping, flush and response registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q      <= '0;
         m_tag_q      <= '0;
         m_idx_q      <= '0;
         m_wsel_q     <= '0;
         beat_q       <= '0;
         req_addr_q   <= '0;
         flush_pend_q <= 1'b0;
         block_q      <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_fault_q <= 1'b0;
         resp_instr_q <= NOP_WORD;
      end else begin
         resp_valid_q <= 1'b0;
         block_q      <= 1'b0;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (misaligned) begin
                     resp_valid_q <= 1'b1;
                     resp_fault_q <= 1'b1;
                     resp_instr_q <= NOP_WORD;
                  end else if (hit) begin
                     resp_valid_q <= 1'b1;
                     resp_fault_q <= 1'b0;
                     resp_instr_q <= data_q[f_idx][f_wsel];
                  end else begin
                     m_tag_q    <= f_tag;
                     m_idx_q    <= f_idx;
                     m_wsel_q   <= f_wsel;
                     req_addr_q <= {fetch_address[ADDR_WIDTH-1:LOFF_W], {LOFF_W{1'b0}}};
                     beat_q     <= '0;
                  end
               end
               // Lookup above used the pre-flush valid bits.
               if (flush) valid_q <= '0;
            end
            REQ: begin
               if (flush) flush_pend_q <= 1'b1;
            end
            FILL: begin
               if (flush) flush_pend_q <= 1'b1;
               if (mem_resp_valid) beat_q <= beat_q + 1'b1;
               if (last_beat) begin
                  valid_q[m_idx_q] <= 1'b1;
                  resp_valid_q     <= 1'b1;
                  resp_fault_q     <= 1'b0;
                  // The requested word may be the beat arriving right now.
                  resp_instr_q     <= (m_wsel_q == beat_q) ? mem_resp_data
                                                           : data_q[m_idx_q][m_wsel_q];
               end
            end
            RESP: begin
               if (flush || flush_pend_q) begin
                  valid_q      <= '0;
                  block_q      <= 1'b1;
                  flush_pend_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   // Refill data and tag writes (arrays are not reset).
   always_ff @(posedge clock) begin
      if (!reset && state_q == FILL && mem_resp_valid) begin
         data_q[m_idx_q][beat_q] <= mem_resp_data;
         if (last_beat) tag_q[m_idx_q] <= m_tag_q;
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;

   // Saturating hit/miss counters over accepted aligned fetches.
   always_ff @(posedge clock) begin
      if (reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (accept && !misaligned) begin
         if (hit) begin
            if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 32'd1;
         end else begin
            if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 32'd1;
         end
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// tb_instruction_cache: self-checking bench for instruction_cache.
// A line-level cache model predicts hit/miss and memory requests; returned
// data is always the backing-memory word, faults return the NOP word.
module tb_instruction_cache;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 4;
   localparam int NL = 16;
   localparam int LB = LW * 4;
   localparam logic [31:0] NOP = 32'h00000013;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        fetch_valid = 1'b0;
   logic [31:0] fetch_address = '0;
   logic        flush = 1'b0;
   logic        mem_req_ready = 1'b0;
   logic        mem_resp_valid = 1'b0;
   logic [31:0] mem_resp_data = '0;
   logic        fetch_ready, resp_valid, resp_fault, mem_req_valid;
   logic [31:0] resp_instruction, mem_req_address;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   instruction_cache #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WORDS(LW), .NUM_LINES(NL), .NOP_WORD(NOP)
   ) dut (
      .clock(clock), .reset(reset),
      .fetch_valid(fetch_valid), .fetch_address(fetch_address), .fetch_ready(fetch_ready),
      .resp_valid(resp_valid), .resp_instruction(resp_instruction), .resp_fault(resp_fault),
      .flush(flush),
      .mem_req_valid(mem_req_valid), .mem_req_address(mem_req_address),
      .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
      .mem_resp_data(mem_resp_data)
`ifdef ICACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] instr;
      logic        fault;
      int          due;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] req_q[$];

   bit          mvalid[NL];
   int unsigned mline[NL];
   int unsigned m_hits = 0;
   int unsigned m_misses = 0;

   int force_delay = -1;
   bit gaps_en = 1'b1;
   int fill_limit = LW;
   int aborted = 0;
   int stray_req = 0;
   int stray_done = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
   endtask

   function automatic logic [31:0] memword(input logic [31:0] a);
      logic [31:0] w;
      w = a & 32'hFFFF_FFFC;
      case (w)
         32'h0:   return 32'h00500113;
         32'h4:   return 32'h00700093;
         32'h8:   return 32'h001101B3;
         32'hC:   return 32'h003181B3;
         default: return (w * 32'h9E3779B1) ^ 32'h13579BDF;
      endcase
   endfunction

   task automatic clear_model();
      for (int i = 0; i < NL; i++) mvalid[i] = 1'b0;
   endtask

   // Issue one fetch (optionally with flush in the same cycle); returns at the
   // negedge following acceptance.
   task automatic fetch(input logic [31:0] a, input bit fl);
      int n;
      int unsigned line, idx;
      exp_t e;
      bit miss;
      n = 0;
      while ((!fetch_ready || reset) && n < 500) begin
         @(negedge clock);
         n++;
      end
      if (!fetch_ready) begin
         timeout_fail("fetch_ready_wait");
         return;
      end
      line = a / LB;
      idx  = line % NL;
      miss = 1'b0;
      if (a[1:0] != 2'b00) begin
         e = '{NOP, 1'b1, cyc + 1};
      end else if (mvalid[idx] && mline[idx] == line) begin
         e = '{memword(a), 1'b0, cyc + 1};
         m_hits++;
      end else begin
         e = '{memword(a), 1'b0, -1};
         req_q.push_back(line * LB);
         m_misses++;
         miss = 1'b1;
      end
      if (fl) clear_model();
      if (miss) begin
         mvalid[idx] = 1'b1;
         mline[idx]  = line;
      end
      exp_q.push_back(e);
      fetch_valid   = 1'b1;
      fetch_address = a;
      flush         = fl;
      @(negedge clock);
      fetch_valid = 1'b0;
      flush       = 1'b0;
   endtask

   task automatic wait_resp();
      int n;
      n = 0;
      while (!resp_valid && n < 300) begin
         @(negedge clock);
         n++;
      end
      if (!resp_valid) timeout_fail("resp_wait");
   endtask

   task automatic check_reset_outputs();
      chk("rst_fetch_ready", {31'b0, fetch_ready}, 32'd0);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_resp_fault", {31'b0, resp_fault}, 32'd0);
      chk("rst_resp_instruction", resp_instruction, NOP);
      chk("rst_mem_req_valid", {31'b0, mem_req_valid}, 32'd0);
      chk("rst_mem_req_address", mem_req_address, 32'd0);
`ifdef ICACHE_STATS_EN
      chk("rst_hit_count", hit_count, 32'd0);
      chk("rst_miss_count", miss_count, 32'd0);
`endif
   endtask

   // Backing memory: random (or forced) request-accept delay, beats with gaps.
   initial begin
      logic [31:0] base;
      int d;
      forever begin
         @(negedge clock);
         if (stray_req != stray_done) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = 32'hDEADBEEF;
            @(negedge clock);
            mem_resp_valid = 1'b0;
            stray_done++;
         end else if (mem_req_valid && !reset) begin
            base = mem_req_address;
            d = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 3));
            repeat (d) @(negedge clock);
            mem_req_ready = 1'b1;
            @(negedge clock);
            mem_req_ready = 1'b0;
            for (int b = 0; b < fill_limit; b++) begin
               if (gaps_en) repeat ($urandom_range(0, 2)) @(negedge clock);
               mem_resp_valid = 1'b1;
               mem_resp_data  = memword(base + 32'(4 * b));
               @(negedge clock);
               mem_resp_valid = 1'b0;
            end
            if (fill_limit < LW) aborted++;
         end
      end
   end

   // Compare process: responses and memory requests against the model.
   initial begin
      exp_t e;
      bit req_active;
      logic [31:0] cur_addr;
      req_active = 1'b0;
      cur_addr   = '0;
      forever begin
         @(negedge clock);
         if (reset) begin
            exp_q.delete();
            req_active = 1'b0;
         end else begin
            if (resp_valid) begin
               if (exp_q.size() == 0) begin
                  chk("resp_unexpected", {31'b0, resp_valid}, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("resp_instruction", resp_instruction, e.instr);
                  chk("resp_fault", {31'b0, resp_fault}, {31'b0, e.fault});
                  if (e.due >= 0) chk("resp_cycle", cyc, e.due);
               end
            end else if (exp_q.size() > 0 && exp_q[0].due >= 0 && cyc >= exp_q[0].due) begin
               chk("resp_valid_on_time", {31'b0, resp_valid}, 32'd1);
               void'(exp_q.pop_front());
            end
            if (mem_req_valid) begin
               if (!req_active) begin
                  if (req_q.size() == 0) begin
                     chk("mem_req_unexpected", {31'b0, mem_req_valid}, 32'd0);
                     cur_addr = mem_req_address;
                  end else begin
                     cur_addr = req_q.pop_front();
                  end
                  req_active = 1'b1;
               end
               chk("mem_req_address", mem_req_address, cur_addr);
            end else begin
               req_active = 1'b0;
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

   // Directed scenarios followed by randomized traffic.
   initial begin
      int ab0;
      int n;
      logic [31:0] a;
      clear_model();
      reset = 1'b1;
      repeat (2) @(negedge clock);
      check_reset_outputs();
      reset = 1'b0;

      // Cold miss on line 0, then three back-to-back hits.
      fetch(32'h0, 1'b0);
      wait_resp();
      chk("first_miss_instr", resp_instruction, 32'h00500113);
      chk("first_miss_fault", {31'b0, resp_fault}, 32'd0);
      fetch(32'h4, 1'b0);
      chk("hit_0x4", resp_instruction, 32'h00700093);
      fetch(32'h8, 1'b0);
      chk("hit_0x8", resp_instruction, 32'h001101B3);
      fetch(32'hC, 1'b0);
      chk("hit_0xC", resp_instruction, 32'h003181B3);
`ifdef ICACHE_STATS_EN
      chk("stats_hits_3", hit_count, 32'd3);
      chk("stats_miss_1", miss_count, 32'd1);
`endif

      // Misaligned fetch.
      fetch(32'h2, 1'b0);
      chk("fault_flag", {31'b0, resp_fault}, 32'd1);
      chk("fault_instr", resp_instruction, 32'h00000013);

      // Conflict misses on index 0.
      fetch(32'h100, 1'b0);
      wait_resp();
      fetch(32'h0, 1'b0);
      wait_resp();

      // Flush while idle, then refetch.
      n = 0;
      while (!fetch_ready && n < 50) begin @(negedge clock); n++; end
      flush = 1'b1;
      clear_model();
      @(negedge clock);
      flush = 1'b0;
      fetch(32'h4, 1'b0);
      wait_resp();

      // Flush during refill: response delivered, one blocked cycle, then miss.
      fetch(32'h20, 1'b0);
      n = 0;
      while (n < 2) begin
         @(posedge clock);
         if (mem_resp_valid) n++;
      end
      @(negedge clock);
      flush = 1'b1;
      clear_model();
      @(negedge clock);
      flush = 1'b0;
      wait_resp();
      chk("flush_fill_instr", resp_instruction, memword(32'h20));
      @(negedge clock);
      chk("ready_blocked_after_flush", {31'b0, fetch_ready}, 32'd0);
      @(negedge clock);
      chk("ready_restored", {31'b0, fetch_ready}, 32'd1);
      fetch(32'h0, 1'b0);
      wait_resp();

      // Slow request accept with gapped beats.
      force_delay = 5;
      fetch(32'h208, 1'b0);
      wait_resp();
      chk("slow_fill_instr", resp_instruction, memword(32'h208));
      force_delay = -1;

      // Reset in the middle of a refill, then a stray beat.
      fill_limit = 2;
      ab0 = aborted;
      fetch(32'h40, 1'b0);
      n = 0;
      while (aborted == ab0 && n < 100) begin @(negedge clock); n++; end
      if (aborted == ab0) timeout_fail("partial_fill_wait");
      fill_limit = LW;
      reset = 1'b1;
      repeat (2) @(negedge clock);
      check_reset_outputs();
      reset = 1'b0;
      clear_model();
      m_hits   = 0;
      m_misses = 0;
      stray_req++;
      repeat (4) @(negedge clock);
      fetch(32'h0, 1'b0);
      wait_resp();
      fetch(32'h44, 1'b0);
      wait_resp();
      chk("post_reset_refill", resp_instruction, memword(32'h44));

      // Randomized traffic over four tags per index.
      for (int i = 0; i < 300; i++) begin
         a = 32'($urandom_range(0, 255)) * 32'd4;
         if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
         fetch(a, ($urandom_range(0, 15) == 0));
      end

      repeat (30) @(negedge clock);
      chk("pending_responses", 32'(exp_q.size()), 32'd0);
      chk("pending_requests", 32'(req_q.size()), 32'd0);
`ifdef ICACHE_STATS_EN
      chk("hit_count", hit_count, m_hits);
      chk("miss_count", miss_count, m_misses);
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
